sha256_stream_core: RTL and testbench

SHA256_STREAM_CORE -- requirements
Module: sha256_stream_core

---
 rtl/sha256_stream_core.sv | 184 ++++++++++++++++++
 tb/tb_sha256_stream_core.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_stream_core.sv
// rtl/sha256_stream_core.sv - SHA-256 compression core accepting padded 512-bit blocks
module sha256_stream_core #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    input  logic         blk_first,
    input  logic         blk_last,
    output logic         digest_valid,
    input  logic         digest_ready,
    output logic [255:0] digest,
    output logic         busy
);

    generate
        if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
              ROUNDS_PER_CYCLE == 4 || ROUNDS_PER_CYCLE == 8)) begin : g_bad_rounds
            $error("sha256_stream_core: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
        end
    endgenerate

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    typedef enum logic [1:0] {IDLE, ROUND, UPDATE, DONE} state_t;

    state_t      state, state_next;
    logic [31:0] hv [8];
    logic [31:0] wv [8];
    logic [31:0] win [16];
    logic [31:0] wv_next [8];
    logic [31:0] win_next [16];
    logic [31:0] h_sum [8];
    logic [255:0] h_sum_flat;
    logic [31:0] t1, t2, w_new;
    logic [5:0]  rnd;
    logic        last_q;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_s0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_s1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Unrolled rounds; win[0] always holds W[t] for the round about to run.
    always_comb begin
        wv_next = wv;
        win_next = win;
        t1 = '0;
        t2 = '0;
        w_new = '0;
        for (int i = 0; i < ROUNDS_PER_CYCLE; i++) begin
            t1 = wv_next[7] + big_s1(wv_next[4])
               + ((wv_next[4] & wv_next[5]) ^ (~wv_next[4] & wv_next[6]))
               + K[rnd + 6'(i)] + win_next[0];
            t2 = big_s0(wv_next[0])
               + ((wv_next[0] & wv_next[1]) ^ (wv_next[0] & wv_next[2]) ^ (wv_next[1] & wv_next[2]));
            w_new = small_s1(win_next[14]) + win_next[9] + small_s0(win_next[1]) + win_next[0];
            wv_next[7] = wv_next[6];
            wv_next[6] = wv_next[5];
            wv_next[5] = wv_next[4];
            wv_next[4] = wv_next[3] + t1;
            wv_next[3] = wv_next[2];
            wv_next[2] = wv_next[1];
            wv_next[1] = wv_next[0];
            wv_next[0] = t1 + t2;
            for (int j = 0; j < 15; j++) begin
                win_next[j] = win_next[j + 1];
            end
            win_next[15] = w_new;
        end
    end

    always_comb begin
        h_sum_flat = '0;
        for (int i = 0; i < 8; i++) begin
            h_sum[i] = hv[i] + wv[i];
            h_sum_flat[255 - 32 * i -: 32] = h_sum[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        blk_ready = 1'b0;
        digest_valid = 1'b0;
        busy = 1'b1;
        case (state)
            IDLE: begin
                blk_ready = 1'b1;
                busy = 1'b0;
                if (blk_valid) state_next = ROUND;
            end
            ROUND: begin
                if (rnd == 6'(64 - ROUNDS_PER_CYCLE)) state_next = UPDATE;
            end
            UPDATE: begin
                state_next = last_q ? DONE : IDLE;
            end
            DONE: begin
                digest_valid = 1'b1;
                if (digest_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hv <= IV;
            digest <= '0;
            rnd <= '0;
            last_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (blk_valid) begin
                        last_q <= blk_last;
                        rnd <= '0;
                        for (int i = 0; i < 16; i++) begin
                            win[i] <= blk_data[511 - 32 * i -: 32];
                        end
                        // A new message drops whatever chain was in progress.
                        if (blk_first) begin
                            hv <= IV;
                            wv <= IV;
                        end else begin
                            wv <= hv;
                        end
                    end
                end
                ROUND: begin
                    wv <= wv_next;
                    win <= win_next;
                    rnd <= rnd + 6'(ROUNDS_PER_CYCLE);
                end
                UPDATE: begin
                    hv <= h_sum;
                    if (last_q) digest <= h_sum_flat;
                end
                DONE: begin
                    if (digest_ready) hv <= IV;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_stream_core.sv
// tb/tb_sha256_stream_core.sv - randomized model-checked bench for sha256_stream_core (R=1 and R=4 instances)
module tb_sha256_stream_core;

    localparam int RPC [2] = '{1, 4};
    localparam logic [255:0] IVF = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    localparam logic [511:0] BLK_ABC = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] BLK_TWO_A = 512'h6162636462636465636465666465666765666768666768696768696a68696a6b696a6b6c6a6b6c6d6b6c6d6e6c6d6e6f6d6e6f706e6f70718000000000000000;
    localparam logic [511:0] BLK_TWO_B = {448'h0, 64'h1c0};
    localparam logic [255:0] DIG_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_TWO = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    logic         clk;
    logic         reset [2];
    logic         blk_valid [2];
    logic         blk_ready [2];
    logic [511:0] blk_data [2];
    logic         blk_first [2];
    logic         blk_last [2];
    logic         digest_valid [2];
    logic         digest_ready [2];
    logic [255:0] digest [2];
    logic         busy [2];

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int acc_cyc [2];
    bit chk_en = 0;

    bit           m_ready [2];
    bit           m_dv [2];
    logic [255:0] m_dig [2];
    logic [255:0] m_h [2];
    logic [255:0] pend_h [2];
    bit           pend_last [2];
    int           m_cnt [2];

    sha256_stream_core #(.ROUNDS_PER_CYCLE(1)) dut1 (
        .clk(clk), .reset(reset[0]), .blk_valid(blk_valid[0]), .blk_ready(blk_ready[0]),
        .blk_data(blk_data[0]), .blk_first(blk_first[0]), .blk_last(blk_last[0]),
        .digest_valid(digest_valid[0]), .digest_ready(digest_ready[0]), .digest(digest[0]), .busy(busy[0]));

    sha256_stream_core #(.ROUNDS_PER_CYCLE(4)) dut4 (
        .clk(clk), .reset(reset[1]), .blk_valid(blk_valid[1]), .blk_ready(blk_ready[1]),
        .blk_data(blk_data[1]), .blk_first(blk_first[1]), .blk_last(blk_last[1]),
        .digest_valid(digest_valid[1]), .digest_ready(digest_ready[1]), .digest(digest[1]), .busy(busy[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Whole-block compression with a full 64-entry schedule.
    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] s [8];
        logic [31:0] x1, x2;
        logic [255:0] r;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32 * t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        for (int i = 0; i < 8; i++) s[i] = hin[255 - 32 * i -: 32];
        for (int t = 0; t < 64; t++) begin
            x1 = s[7] + (ror(s[4], 6) ^ ror(s[4], 11) ^ ror(s[4], 25))
               + ((s[4] & s[5]) ^ (~s[4] & s[6])) + KT[t] + w[t];
            x2 = (ror(s[0], 2) ^ ror(s[0], 13) ^ ror(s[0], 22))
               + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
            for (int i = 7; i > 0; i--) s[i] = s[i-1];
            s[4] = s[4] + x1;
            s[0] = x1 + x2;
        end
        for (int i = 0; i < 8; i++) r[255 - 32 * i -: 32] = hin[255 - 32 * i -: 32] + s[i];
        return r;
    endfunction

    // Timer-based reference: a block occupies the core for 64/R+1 cycles after acceptance.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset[k]) begin
                m_cnt[k] = 0; m_ready[k] = 1; m_dv[k] = 0; m_dig[k] = '0; m_h[k] = IVF;
            end else if (m_ready[k] && blk_valid[k]) begin
                pend_h[k] = compress(blk_first[k] ? IVF : m_h[k], blk_data[k]);
                pend_last[k] = blk_last[k];
                m_ready[k] = 0;
                m_cnt[k] = 64 / RPC[k] + 1;
            end else if (m_cnt[k] > 0) begin
                m_cnt[k] = m_cnt[k] - 1;
                if (m_cnt[k] == 0) begin
                    m_h[k] = pend_h[k];
                    if (pend_last[k]) begin
                        m_dv[k] = 1; m_dig[k] = pend_h[k];
                    end else begin
                        m_ready[k] = 1;
                    end
                end
            end else if (m_dv[k] && digest_ready[k]) begin
                m_dv[k] = 0; m_ready[k] = 1; m_h[k] = IVF;
            end
        end
    end

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %h required %h", nm, act, exp);
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        $display("FAIL %s: no response within cycle budget", nm);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("r%0d blk_ready", RPC[k]), 256'(blk_ready[k]), 256'(m_ready[k]));
                check($sformatf("r%0d digest_valid", RPC[k]), 256'(digest_valid[k]), 256'(m_dv[k]));
                check($sformatf("r%0d busy", RPC[k]), 256'(busy[k]), 256'(!m_ready[k]));
                check($sformatf("r%0d digest", RPC[k]), digest[k], m_dig[k]);
            end
        end
    end

    task automatic send(input int k, input logic [511:0] d, input bit f, input bit l);
        int n = 0;
        blk_data[k] = d; blk_first[k] = f; blk_last[k] = l; blk_valid[k] = 1;
        while (!blk_ready[k] && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) timeout("send");
        @(negedge clk);
        acc_cyc[k] = cyc;
    endtask

    task automatic wait_digest(input int k, input int hold, output logic [255:0] d, output int lat);
        int n = 0;
        while (!digest_valid[k] && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) timeout("digest_valid");
        lat = cyc - acc_cyc[k];
        d = digest[k];
        repeat (hold) begin
            @(negedge clk);
            check("hold blk_ready", 256'(blk_ready[k]), 256'(0));
            check("hold digest_valid", 256'(digest_valid[k]), 256'(1));
        end
        digest_ready[k] = 1;
        @(negedge clk);
        digest_ready[k] = 0;
        check("post-take blk_ready", 256'(blk_ready[k]), 256'(1));
        check("post-take digest_valid", 256'(digest_valid[k]), 256'(0));
    endtask

    task automatic run_rand(input int k, input int nblk);
        logic [511:0] rd;
        logic [255:0] d;
        int lat;
        bit f, l;
        for (int b = 0; b < nblk; b++) begin
            for (int j = 0; j < 16; j++) rd[32 * j +: 32] = $urandom;
            f = ($urandom_range(2) == 0);
            l = (b == nblk - 1) || ($urandom_range(2) == 0);
            send(k, rd, f, l);
            if ($urandom_range(1) == 1) begin
                blk_valid[k] = 0;
                repeat ($urandom_range(3)) @(negedge clk);
            end
            if (l) begin
                blk_valid[k] = 0;
                wait_digest(k, $urandom_range(4), d, lat);
                check($sformatf("r%0d random latency", RPC[k]), 256'(lat), 256'(64 / RPC[k] + 1));
            end
        end
        blk_valid[k] = 0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [255:0] d;
        int lat;
        int n;
        for (int k = 0; k < 2; k++) begin
            reset[k] = 1; blk_valid[k] = 0; blk_data[k] = '0;
            blk_first[k] = 0; blk_last[k] = 0; digest_ready[k] = 0;
        end
        repeat (3) @(negedge clk);
        reset[0] = 0; reset[1] = 0;
        chk_en = 1;
        check("reset blk_ready", 256'(blk_ready[0]), 256'(1));
        check("reset busy", 256'(busy[0]), 256'(0));
        check("reset digest", digest[0], 256'h0);

        check("model abc", compress(IVF, BLK_ABC), DIG_ABC);
        check("model two-block", compress(compress(IVF, BLK_TWO_A), BLK_TWO_B), DIG_TWO);
        check("model empty", compress(IVF, BLK_EMPTY), DIG_EMPTY);

        send(0, BLK_ABC, 1, 1);
        blk_valid[0] = 0;
        wait_digest(0, 0, d, lat);
        check("r1 abc digest", d, DIG_ABC);
        check("r1 abc latency", 256'(lat), 256'(65));

        send(1, BLK_ABC, 1, 1);
        blk_valid[1] = 0;
        wait_digest(1, 0, d, lat);
        check("r4 abc digest", d, DIG_ABC);
        check("r4 abc latency", 256'(lat), 256'(17));

        send(0, BLK_TWO_A, 1, 0);
        n = 0;
        while (!blk_ready[0] && n < 200) begin @(negedge clk); n++; end
        check("two-block ready latency", 256'(cyc - acc_cyc[0]), 256'(65));
        send(0, BLK_TWO_B, 0, 1);
        blk_valid[0] = 0;
        wait_digest(0, 0, d, lat);
        check("two-block digest", d, DIG_TWO);

        send(0, BLK_EMPTY, 1, 1);
        blk_valid[0] = 0;
        wait_digest(0, 10, d, lat);
        check("empty digest", d, DIG_EMPTY);

        send(0, BLK_TWO_A, 1, 0);
        send(0, BLK_ABC, 1, 1);
        blk_valid[0] = 0;
        wait_digest(0, 0, d, lat);
        check("restart mid-message digest", d, DIG_ABC);

        send(0, BLK_ABC, 1, 1);
        blk_valid[0] = 0;
        repeat (30) @(negedge clk);
        reset[0] = 1;
        @(negedge clk);
        check("mid-round reset busy", 256'(busy[0]), 256'(0));
        check("mid-round reset digest_valid", 256'(digest_valid[0]), 256'(0));
        reset[0] = 0;
        send(0, BLK_ABC, 0, 1);
        blk_valid[0] = 0;
        wait_digest(0, 0, d, lat);
        check("abc after reset digest", d, DIG_ABC);

        fork
            run_rand(0, 20);
            run_rand(1, 30);
        join
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
